// File: rtl/frodo_pkg.sv
// Shared definitions for the FrodoKEM matrix-product address generator:
// mode encodings, controller states and default sizing.
package frodo_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int LANES_DEF  = 4;
  localparam int DIM_W_DEF  = 11;

  typedef enum logic [1:0] {
    MODE_AB  = 2'b00,
    MODE_ATB = 2'b01,
    MODE_ABE = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // True when any loop bound is zero, i.e. the product is empty.
  function automatic logic dims_empty(input logic [DIM_W_DEF-1:0] m,
                                      input logic [DIM_W_DEF-1:0] k,
                                      input logic [DIM_W_DEF-1:0] jw);
    return (m == '0) || (k == '0) || (jw == '0);
  endfunction

endpackage

// File: rtl/frodo_mm_agu_if.sv
// Read/MAC/write bus between the address generator and the RAMs plus MAC
// array. The generator drives everything through the master modport.
interface frodo_mm_agu_if
  import frodo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [ADDR_W-1:0] rd_addr_e;
  logic              rd_en_a;
  logic              rd_en_b;
  logic              rd_en_e;
  logic              acc_clr;
  logic              acc_last;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  modport master (
    output rd_addr_a, rd_addr_b, rd_addr_e,
    output rd_en_a, rd_en_b, rd_en_e,
    output acc_clr, acc_last,
    output wr_addr, wr_en
  );

  modport slave (
    input rd_addr_a, rd_addr_b, rd_addr_e,
    input rd_en_a, rd_en_b, rd_en_e,
    input acc_clr, acc_last,
    input wr_addr, wr_en
  );

endinterface

// File: rtl/frodo_nest_cnt.sv
// Three-level wrapping loop counter (k innermost, then jg, then i) that also
// keeps the running products i*K, k*M, k*JW and i*JW using adders only.
module frodo_nest_cnt
  import frodo_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              step,
  input  logic [DIM_W-1:0]  bound_k,
  input  logic [DIM_W-1:0]  bound_jw,
  input  logic [DIM_W-1:0]  bound_m,
  output logic [DIM_W-1:0]  k,
  output logic [DIM_W-1:0]  jg,
  output logic [DIM_W-1:0]  i,
  output logic              k_first,
  output logic              k_last,
  output logic              final_tuple,
  output logic [ADDR_W-1:0] off_ik,
  output logic [ADDR_W-1:0] off_km,
  output logic [ADDR_W-1:0] off_kjw,
  output logic [ADDR_W-1:0] off_ijw
);

  logic jg_last;
  logic i_last;

  // Position flags relative to the latched loop bounds.
  always_comb begin
    k_first     = (k == '0);
    k_last      = (k == bound_k - DIM_W'(1));
    jg_last     = (jg == bound_jw - DIM_W'(1));
    i_last      = (i == bound_m - DIM_W'(1));
    final_tuple = k_last & jg_last & i_last;
  end

  // Advance the nest one tuple per step; offsets track the index products.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k       <= '0;
      jg      <= '0;
      i       <= '0;
      off_ik  <= '0;
      off_km  <= '0;
      off_kjw <= '0;
      off_ijw <= '0;
    end else if (clear) begin
      k       <= '0;
      jg      <= '0;
      i       <= '0;
      off_ik  <= '0;
      off_km  <= '0;
      off_kjw <= '0;
      off_ijw <= '0;
    end else if (step) begin
      if (k_last) begin
        k       <= '0;
        off_km  <= '0;
        off_kjw <= '0;
        if (jg_last) begin
          jg <= '0;
          if (i_last) begin
            i       <= '0;
            off_ik  <= '0;
            off_ijw <= '0;
          end else begin
            i       <= i + DIM_W'(1);
            off_ik  <= off_ik + ADDR_W'(bound_k);
            off_ijw <= off_ijw + ADDR_W'(bound_jw);
          end
        end else begin
          jg <= jg + DIM_W'(1);
        end
      end else begin
        k       <= k + DIM_W'(1);
        off_km  <= off_km + ADDR_W'(bound_m);
        off_kjw <= off_kjw + ADDR_W'(bound_jw);
      end
    end
  end

endmodule

// File: rtl/frodo_mm_agu.sv
// Loop/address generator for FrodoKEM C = A*B (+E): walks (i, jg, k), issues
// A/B/E read addresses, MAC clear/last sidebands aligned to returned data,
// and the C write address once each dot product leaves the MAC pipeline.
module frodo_mm_agu
  import frodo_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int DIM_W   = DIM_W_DEF,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_jw,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_e,
  input  logic [ADDR_W-1:0] base_c,
  input  logic              en,
  frodo_mm_agu_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WL = RD_LAT + MAC_LAT;

  if (RD_LAT < 1 || LANES < 1) begin : g_bad_cfg
    $error("frodo_mm_agu: RD_LAT and LANES must be at least 1");
  end

  state_e            state;
  state_e            state_nxt;
  mode_e             mode_q;
  logic              err_q;
  logic [DIM_W-1:0]  dim_m_q;
  logic [DIM_W-1:0]  dim_k_q;
  logic [DIM_W-1:0]  dim_jw_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] base_e_q;
  logic [ADDR_W-1:0] base_c_q;

  logic              launch;
  logic              issue;
  logic              wr_pending;

  logic [DIM_W-1:0]  k;
  logic [DIM_W-1:0]  jg;
  logic [DIM_W-1:0]  i;
  logic              k_first;
  logic              k_last;
  logic              final_tuple;
  logic [ADDR_W-1:0] off_ik;
  logic [ADDR_W-1:0] off_km;
  logic [ADDR_W-1:0] off_kjw;
  logic [ADDR_W-1:0] off_ijw;
  logic [ADDR_W-1:0] a_off;
  logic [ADDR_W-1:0] row_word;

  logic [RD_LAT-1:0] clr_dl;
  logic [RD_LAT-1:0] last_dl;
  logic [WL-1:0]     wv_dl;
  logic [ADDR_W-1:0] wa_dl [WL];

  assign launch = (state == ST_IDLE) && en && start;
  assign issue  = (state == ST_RUN) && en;

  // Capture the job description on an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= MODE_AB;
      err_q    <= 1'b0;
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_jw_q <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_e_q <= '0;
      base_c_q <= '0;
    end else if (launch) begin
      mode_q   <= mode_e'(mode);
      err_q    <= (mode_e'(mode) == MODE_ILL);
      dim_m_q  <= dim_m;
      dim_k_q  <= dim_k;
      dim_jw_q <= dim_jw;
      base_a_q <= base_a;
      base_b_q <= base_b;
      base_e_q <= base_e;
      base_c_q <= base_c;
    end
  end

  frodo_nest_cnt #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (launch),
    .step        (issue),
    .bound_k     (dim_k_q),
    .bound_jw    (dim_jw_q),
    .bound_m     (dim_m_q),
    .k           (k),
    .jg          (jg),
    .i           (i),
    .k_first     (k_first),
    .k_last      (k_last),
    .final_tuple (final_tuple),
    .off_ik      (off_ik),
    .off_km      (off_km),
    .off_kjw     (off_kjw),
    .off_ijw     (off_ijw)
  );

  // Controller state register; en low holds the controller where it is.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: illegal mode or empty dims skip straight to DONE.
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mode_e'(mode) == MODE_ILL || dims_empty(dim_m, dim_k, dim_jw))
              state_nxt = ST_DONE;
            else
              state_nxt = ST_RUN;
          end
        end
        ST_RUN:   if (final_tuple) state_nxt = ST_DRAIN;
        ST_DRAIN: if (!wr_pending) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Writes still queued behind the one currently leaving the pipeline.
  always_comb begin
    wr_pending = 1'b0;
    for (int s = 0; s < WL - 1; s++) wr_pending = wr_pending | wv_dl[s];
  end

  // Sideband and write delay lines; they only shift while en is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_dl  <= '0;
      last_dl <= '0;
      wv_dl   <= '0;
      for (int s = 0; s < WL; s++) wa_dl[s] <= '0;
    end else if (en) begin
      clr_dl[0]  <= issue & k_first;
      last_dl[0] <= issue & k_last;
      for (int s = 1; s < RD_LAT; s++) begin
        clr_dl[s]  <= clr_dl[s-1];
        last_dl[s] <= last_dl[s-1];
      end
      wv_dl[0] <= issue & k_last;
      wa_dl[0] <= base_c_q + row_word;
      for (int s = 1; s < WL; s++) begin
        wv_dl[s] <= wv_dl[s-1];
        wa_dl[s] <= wa_dl[s-1];
      end
    end
  end

  // Address arithmetic from the running offsets; A is walked column-wise
  // when transposed.
  always_comb begin
    a_off    = (mode_q == MODE_ATB) ? (off_km + ADDR_W'(i)) : (off_ik + ADDR_W'(k));
    row_word = off_ijw + ADDR_W'(jg);
  end

  assign bus.rd_addr_a = base_a_q + a_off;
  assign bus.rd_addr_b = base_b_q + off_kjw + ADDR_W'(jg);
  assign bus.rd_addr_e = base_e_q + row_word;
  assign bus.rd_en_a   = issue;
  assign bus.rd_en_b   = issue;
  assign bus.rd_en_e   = issue & k_last & (mode_q == MODE_ABE);
  assign bus.acc_clr   = en & clr_dl[RD_LAT-1];
  assign bus.acc_last  = en & last_dl[RD_LAT-1];
  assign bus.wr_en     = en & wv_dl[WL-1];
  assign bus.wr_addr   = wa_dl[WL-1];

  assign busy = (state != ST_IDLE);
  assign done = en & (state == ST_DONE);
  assign err  = done & err_q;

endmodule

// File: tb/tb_frodo_mm_agu.sv
// Self-checking bench for frodo_mm_agu. Expected behaviour comes from a
// tuple-list model: the n-th en-high cycle after start issues tuple n-1 of
// the (i, jg, k) nest, sidebands appear RD_LAT active cycles later, writes
// RD_LAT+MAC_LAT active cycles later, and done one active cycle after that.
module tb_frodo_mm_agu;

  localparam int ADDR_W  = 13;
  localparam int DIM_W   = 11;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 2;
  localparam int LAT     = RD_LAT + MAC_LAT;
  localparam int AMASK   = (1 << ADDR_W) - 1;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [1:0]        mode;
  logic [DIM_W-1:0]  dim_m, dim_k, dim_jw;
  logic [ADDR_W-1:0] base_a, base_b, base_e, base_c;
  logic              en;
  logic              busy, done, err;

  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  int    fail_cnt = 0;
  string cur_job  = "reset";

  int j_md, j_m, j_k, j_jw, j_ba, j_bb, j_be, j_bc;

  frodo_mm_agu_if #(.ADDR_W(ADDR_W)) bus ();

  frodo_mm_agu #(
    .ADDR_W (ADDR_W), .LANES (4), .DIM_W (DIM_W),
    .RD_LAT (RD_LAT), .MAC_LAT (MAC_LAT)
  ) dut (
    .clk (clk), .rstn (rstn), .start (start), .mode (mode),
    .dim_m (dim_m), .dim_k (dim_k), .dim_jw (dim_jw),
    .base_a (base_a), .base_b (base_b), .base_e (base_e), .base_c (base_c),
    .en (en), .bus (bus), .busy (busy), .done (done), .err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt = chk_cnt + 1;
    assert (obs === expv) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("[TB] FAIL %s/%s: observed %0h expected %0h", cur_job, name, obs, expv);
    end
  endtask

  function automatic int idxK(input int t); return t % j_k; endfunction
  function automatic int idxJ(input int t); return (t / j_k) % j_jw; endfunction
  function automatic int idxI(input int t); return t / (j_k * j_jw); endfunction

  // Present a job with a start pulse; called just after a rising edge.
  task automatic applyStimulus(input int md, input int m, input int kk, input int jw,
                               input int ba, input int bb, input int be, input int bc);
    j_md = md; j_m = m; j_k = kk; j_jw = jw;
    j_ba = ba; j_bb = bb; j_be = be; j_bc = bc;
    mode   = md[1:0];
    dim_m  = m[DIM_W-1:0];
    dim_k  = kk[DIM_W-1:0];
    dim_jw = jw[DIM_W-1:0];
    base_a = ba[ADDR_W-1:0];
    base_b = bb[ADDR_W-1:0];
    base_e = be[ADDR_W-1:0];
    base_c = bc[ADDR_W-1:0];
    en     = 1'b1;
    start  = 1'b1;
  endtask

  // Compare every output against the model for active-cycle index a.
  task automatic checkCycle(input int a, input logic e);
    int n, t, ta, tw;
    logic exp_rd, exp_e, exp_clr, exp_last, exp_wr;
    n = j_m * j_k * j_jw;
    t = a - 1;
    ta = a - RD_LAT - 1;
    tw = a - LAT - 1;
    exp_rd   = e && (t >= 0) && (t < n);
    exp_e    = exp_rd && (j_md == 2) && (idxK(t) == j_k - 1);
    exp_clr  = e && (ta >= 0) && (ta < n) && (idxK(ta) == 0);
    exp_last = e && (ta >= 0) && (ta < n) && (idxK(ta) == j_k - 1);
    exp_wr   = e && (tw >= 0) && (tw < n) && (idxK(tw) == j_k - 1);
    checkOutput("rd_en_a", bus.rd_en_a, exp_rd);
    checkOutput("rd_en_b", bus.rd_en_b, exp_rd);
    if (exp_rd) begin
      if (j_md == 1)
        checkOutput("rd_addr_a", bus.rd_addr_a, (j_ba + idxK(t) * j_m + idxI(t)) & AMASK);
      else
        checkOutput("rd_addr_a", bus.rd_addr_a, (j_ba + idxI(t) * j_k + idxK(t)) & AMASK);
      checkOutput("rd_addr_b", bus.rd_addr_b, (j_bb + idxK(t) * j_jw + idxJ(t)) & AMASK);
    end
    checkOutput("rd_en_e", bus.rd_en_e, exp_e);
    if (exp_e)
      checkOutput("rd_addr_e", bus.rd_addr_e, (j_be + idxI(t) * j_jw + idxJ(t)) & AMASK);
    checkOutput("acc_clr", bus.acc_clr, exp_clr);
    checkOutput("acc_last", bus.acc_last, exp_last);
    checkOutput("wr_en", bus.wr_en, exp_wr);
    if (exp_wr)
      checkOutput("wr_addr", bus.wr_addr, (j_bc + idxI(tw) * j_jw + idxJ(tw)) & AMASK);
    checkOutput("done", done, e && (a == n + LAT + 1));
    checkOutput("err", err, 1'b0);
    checkOutput("busy", busy, 1'b1);
  endtask

  function automatic logic pickEn(input int style, input int cyc);
    if (style == 1) return ($urandom_range(0, 9) < 7);
    if (style == 2) return !(cyc == 3 || cyc == 4);
    return 1'b1;
  endfunction

  // Full job: start cycle, then cycle-by-cycle checks until the model's done.
  task automatic runJob(input int md, input int m, input int kk, input int jw,
                        input int ba, input int bb, input int be, input int bc,
                        input int style, input string tag);
    int n, a, cyc;
    logic e;
    cur_job = tag;
    applyStimulus(md, m, kk, jw, ba, bb, be, bc);
    n = m * kk * jw;
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_rd", bus.rd_en_a, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    a = 0;
    cyc = 0;
    while (a < n + LAT + 1 && cyc < 4000) begin
      cyc++;
      e = pickEn(style, cyc);
      en = e;
      if (e) a++;
      @(negedge clk);
      checkCycle(a, e);
      @(posedge clk); #1;
    end
    if (a < n + LAT + 1) checkOutput("timeout", a, n + LAT + 1);
    en = 1'b1;
    @(negedge clk);
    checkOutput("post_done", done, 1'b0);
    checkOutput("post_busy", busy, 1'b0);
    checkOutput("post_wr", bus.wr_en, 1'b0);
    @(posedge clk); #1;
  endtask

  // Illegal mode or empty dims: done (and err for illegal) one cycle later.
  task automatic runTrivial(input int md, input int m, input int kk, input int jw, input string tag);
    cur_job = tag;
    applyStimulus(md, m, kk, jw, 0, 0, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("done", done, 1'b1);
    checkOutput("err", err, (md == 3));
    checkOutput("rd_en_a", bus.rd_en_a, 1'b0);
    checkOutput("rd_en_e", bus.rd_en_e, 1'b0);
    checkOutput("wr_en", bus.wr_en, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("done_clr", done, 1'b0);
    checkOutput("err_clr", err, 1'b0);
    checkOutput("busy_clr", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int md, m, kk, jw;
    rstn = 1'b1; start = 1'b0; en = 1'b1; mode = 2'b00;
    dim_m = '0; dim_k = '0; dim_jw = '0;
    base_a = '0; base_b = '0; base_e = '0; base_c = '0;
    j_md = 0; j_m = 1; j_k = 1; j_jw = 1; j_ba = 0; j_bb = 0; j_be = 0; j_bc = 0;
    #1 rstn = 1'b0;
    #2;
    checkOutput("rst_rd_en_a", bus.rd_en_a, 1'b0);
    checkOutput("rst_rd_addr_a", bus.rd_addr_a, 0);
    checkOutput("rst_wr_en", bus.wr_en, 1'b0);
    checkOutput("rst_wr_addr", bus.wr_addr, 0);
    checkOutput("rst_acc_clr", bus.acc_clr, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    runJob(0, 2, 3, 1, 0, 0, 0, 0, 0, "ab_m2k3jw1");
    runJob(1, 2, 2, 2, 100, 0, 0, 200, 0, "atb_m2k2jw2");
    runJob(2, 1, 2, 2, 0, 10, 50, 300, 0, "abe_m1k2jw2");
    runJob(0, 2, 3, 1, 0, 0, 0, 0, 2, "ab_freeze");
    runJob(0, 2, 1, 3, 7, 9, 0, 20, 0, "ab_k1");
    runTrivial(3, 2, 2, 2, "illegal_mode");
    runTrivial(0, 2, 0, 2, "k_zero");

    cur_job = "reset_mid_run";
    applyStimulus(0, 2, 3, 1, 5, 6, 0, 8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    checkOutput("rd_en_a", bus.rd_en_a, 1'b0);
    checkOutput("rd_addr_b", bus.rd_addr_b, 0);
    checkOutput("wr_en", bus.wr_en, 1'b0);
    checkOutput("acc_last", bus.acc_last, 1'b0);
    checkOutput("busy", busy, 1'b0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    runJob(0, 2, 3, 1, 5, 6, 0, 8, 0, "after_reset");

    for (int r = 0; r < 8; r++) begin
      md = $urandom_range(0, 2);
      m  = $urandom_range(1, 3);
      kk = $urandom_range(1, 4);
      jw = $urandom_range(1, 3);
      runJob(md, m, kk, jw, $urandom_range(0, AMASK), $urandom_range(0, AMASK),
             $urandom_range(0, AMASK), $urandom_range(AMASK - 3, AMASK), 1, "random");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/frodo_mm_agu.md
Name: frodo_mm_agu

Overview:
- Parametrised loop/address generator for FrodoKEM matrix products C = A·B (+E), with 16-bit elements and LANES elements packed per B/C/E word.
- Sits between the matrix RAMs/SHAKE output and the MAC array.
- Walks i (result row), jg (result column-word), k (inner index), issues read addresses and MAC sideband strobes, then writes each finished result word.
- Supports a transposed-A mode and a fused +E accumulate mode; the previous fixed-mode counter skeleton had neither.

Parameters:
- ADDR_W, 13, width of all RAM addresses (element units for A, word units for B/C/E).
- LANES, 4, 16-bit elements per B/C/E word (bus width 16*LANES).
- DIM_W, 11, width of the M/K/JW dimension inputs (max 1344 rows).
- RD_LAT, 1, RAM read latency in cycles.
- MAC_LAT, 2, MAC pipeline depth from operands valid to result valid.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch pulse; dims, mode and bases are sampled on it
- mode  in  2  00 = A·B, 01 = Aᵀ·B, 10 = A·B+E, 11 = illegal
- dim_m  in  DIM_W  result rows
- dim_k  in  DIM_W  inner length
- dim_jw  in  DIM_W  result words per row
- base_a, base_b, base_e, base_c  in  ADDR_W  region bases
- en  in  1  global advance; 0 freezes all state
- rd_addr_a  out  ADDR_W  element address into A
- rd_addr_b  out  ADDR_W  word address into B
- rd_addr_e  out  ADDR_W  word address into E
- rd_en_a, rd_en_b, rd_en_e  out  1  read strobes
- acc_clr  out  1  MAC: first k of a dot product
- acc_last  out  1  MAC: last k; add E lane data if mode 10
- wr_addr  out  ADDR_W  result word address into C
- wr_en  out  1  result write strobe
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on illegal mode

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, delay lines cleared. Reset mid-run aborts with no further wr_en.
- FSM states:
  - IDLE: on start, latch inputs. Mode 11 -> err=1 and done=1 next cycle, return to IDLE. Any dim = 0 -> done next cycle with no strobes. Otherwise go to RUN.
  - RUN: each cycle with en=1, issue one (i,jg,k) tuple. k is innermost, then jg, then i. After the final tuple go to DRAIN.
  - DRAIN: wait until the write pipeline empties, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE. start while busy is ignored.
- Addresses (combinational from registered counters, all mod 2^ADDR_W):
  - mode 00/10: rd_addr_a = base_a + i*K + k
  - mode 01: rd_addr_a = base_a + k*M + i
  - rd_addr_b = base_b + k*JW + jg
  - rd_addr_e = base_e + i*JW + jg, strobed only when k = K-1 and mode = 10
  - wr_addr = base_c + i*JW + jg, taken from the delay line
- Products are maintained incrementally with adders and row-offset registers; no multipliers.
- Timing:
  - rd_en_a and rd_en_b are high in every RUN cycle with en=1.
  - acc_clr and acc_last are delayed RD_LAT cycles, so they align with returned data.
  - wr_en and wr_addr are delayed RD_LAT+MAC_LAT cycles from the k = K-1 issue.
- en=0 freezes counters, all delay lines, and the FSM. Read strobes are 0 during the freeze; delayed strobes hold their stage but are masked to 0 on the outputs. On en=1 the sequence resumes exactly where it stopped.
- K=1: acc_clr and acc_last assert on the same cycle.
- done follows the final wr_en by exactly one cycle when en stays 1.
- Total cycles from start to done with en=1: M*JW*K + RD_LAT + MAC_LAT + 2.

Decomposition:
- Package frodo_pkg holds:
  - mode encodings MODE_AB, MODE_ATB, MODE_ABE, MODE_ILL
  - FSM state enum
  - default LANES/ADDR_W/DIM_W
- Sub-module frodo_nest_cnt: a 3-level wrapping counter (k, jg, i) with en, K/JW/M bounds, first/last/wrap flags, and incremental row-offset tracking. The address adders and delay lines stay in the top.

Test Plan:
- mode 00, M=2, K=3, JW=1, all bases 0 -> rd_addr_a = 0,1,2,3,4,5; rd_addr_b = 0,1,2,0,1,2; wr_en twice, wr_addr 0 then 1; done 11 cycles after start.
- mode 01, M=2, K=2, JW=2, base_a=100 -> rd_addr_a = 100,102,100,102,101,103,101,103; wr_addr = base_c+0..3.
- mode 10, M=1, K=2, JW=2, base_e=50 -> rd_en_e only on k=1 issues at addresses 50 and 51; acc_last aligned RD_LAT cycles later.
- en toggling 1-0-0-1 during RUN of the first case -> identical address/wr_en sequence, stretched by 2 cycles, no duplicated or lost strobes.
- mode 11 -> err and done pulse together one cycle after start, no rd/wr strobes; dim_k=0 -> done only.
- rstn low mid-RUN -> all outputs 0 asynchronously; a new start after release runs a clean full sequence.
